// File: rtl/chunked_add_pkg.sv
// Shared types and elaboration helpers for the chunked wide-adder sequencer.
package chunked_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int cnt_w_f(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  function automatic bit cfg_ok_f(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_add_seq_csa.sv
// Carry-select adder: SIZE-bit blocks precompute both carry-in cases and a
// mux chain picks the right one. The last block may be narrower than SIZE.
module Carry_Select_Adder #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NBLK = (WIDTH + SIZE - 1) / SIZE;

  logic [NBLK:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    localparam int LO = i * SIZE;
    localparam int W  = ((WIDTH - LO) < SIZE) ? (WIDTH - LO) : SIZE;

    logic [W:0] sum0_s;
    logic [W:0] sum1_s;

    assign sum0_s = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]};
    assign sum1_s = {1'b0, a[LO +: W]} + {1'b0, b[LO +: W]} + {{W{1'b0}}, 1'b1};
    assign s[LO +: W]     = carry_s[i] ? sum1_s[W-1:0] : sum0_s[W-1:0];
    assign carry_s[i + 1] = carry_s[i] ? sum1_s[W]     : sum0_s[W];
  end

  assign cout = carry_s[NBLK];

endmodule

// File: rtl/chunked_add_seq.sv
// WIDTH-bit adder built by time-multiplexing one CHUNK-bit carry-select adder,
// least-significant chunk first, behind valid/ready handshakes.
module chunked_add_seq
  import chunked_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int SIZE  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             busy
);

  localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int CW     = cnt_w_f(NCHUNK);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

  if (!cfg_ok_f(WIDTH, CHUNK)) begin : g_cfg_err
    $error("chunked_add_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e state_r;
  state_e next_s;

  logic [CW-1:0]                  idx_r;
  logic                           carry_r;
  logic [NCHUNK-1:0][CHUNK-1:0]   opa_r;
  logic [NCHUNK-1:0][CHUNK-1:0]   opb_r;
  logic [NCHUNK-1:0][CHUNK-1:0]   res_r;
  logic                           out_cout_r;
  logic                           out_valid_r;

  logic [CHUNK-1:0] sum_s;
  logic             cout_s;
  logic             accept_s;
  logic             last_s;
  logic             in_ready_s;

  Carry_Select_Adder #(
    .WIDTH (CHUNK),
    .SIZE  (SIZE)
  ) u_csa (
    .a    (opa_r[idx_r]),
    .b    (opb_r[idx_r]),
    .cin  (carry_r),
    .s    (sum_s),
    .cout (cout_s)
  );

  // out_ready -> in_ready is a deliberate combinational path for back-to-back issue.
  assign in_ready_s = rst_n & ((state_r == IDLE) | ((state_r == DONE) & out_ready));
  assign accept_s   = in_valid & in_ready_s;
  assign last_s     = (idx_r == LAST_IDX);

  // Next-state selection.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_s = RUN;
        else          next_s = IDLE;
      end
      RUN: begin
        if (last_s) next_s = DONE;
        else        next_s = RUN;
      end
      DONE: begin
        if (accept_s)       next_s = RUN;
        else if (out_ready) next_s = IDLE;
        else                next_s = DONE;
      end
      default: next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_s;
  end

  // Operand capture, per-chunk accumulation and result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r       <= {CW{1'b0}};
      carry_r     <= 1'b0;
      opa_r       <= {WIDTH{1'b0}};
      opb_r       <= {WIDTH{1'b0}};
      res_r       <= {WIDTH{1'b0}};
      out_cout_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        opa_r   <= in_a;
        opb_r   <= in_b;
        carry_r <= in_cin;
        idx_r   <= {CW{1'b0}};
      end else if (state_r == RUN) begin
        res_r[idx_r] <= sum_s;
        carry_r      <= cout_s;
        if (last_s) out_cout_r <= cout_s;
        else        idx_r      <= idx_r + CW'(1);
      end else begin
        carry_r <= carry_r;
      end
      out_valid_r <= (next_s == DONE);
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_s     = res_r;
  assign out_cout  = out_cout_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_chunked_add_seq.sv
// Self-checking bench: directed scenarios plus randomized traffic scored
// against a plain-arithmetic queue model.
module tb_chunked_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic [31:0] in_a, in_b, out_s;
  logic        n_in_valid, n_in_ready, n_in_cin, n_out_valid, n_out_ready, n_out_cout, n_busy;
  logic [7:0]  n_in_a, n_in_b, n_out_s;

  int errors = 0;
  int checks = 0;

  chunked_add_seq #(.WIDTH(32), .CHUNK(8), .SIZE(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_s(out_s), .out_cout(out_cout), .busy(busy)
  );

  chunked_add_seq #(.WIDTH(8), .CHUNK(8), .SIZE(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_a(n_in_a), .in_b(n_in_b), .in_cin(n_in_cin), .out_valid(n_out_valid),
    .out_ready(n_out_ready), .out_s(n_out_s), .out_cout(n_out_cout), .busy(n_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Present one operation, then scramble the inputs and wait for out_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       output int lat, output bit busy_all);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    busy_all = busy;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      busy_all &= busy;
      if (out_valid) begin lat = k; break; end
    end
  endtask

  task automatic transfer;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_s !== 32'h0) begin errors++; $display("FAIL reset_out_s: got %h want 0", out_s); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %0b want 0", out_cout); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %0b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_high: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic;
    int lat; bit ba;
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, ba);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if (out_s !== 32'h0) begin errors++; $display("FAIL basic_s: got %h want 00000000", out_s); end
    checks++; if (out_cout !== 1'b1) begin errors++; $display("FAIL basic_cout: got %0b want 1", out_cout); end
    transfer();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got valid=%0b busy=%0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_busy;
    int lat; bit ba;
    issue(32'h1234_5678, 32'h8765_4321, 1'b1, lat, ba);
    checks++; if (out_s !== 32'h9999_999A || out_cout !== 1'b0) begin errors++; $display("FAIL busy_sum: got %0b_%h want 0_9999999a", out_cout, out_s); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL busy_held: got %0b want 1", ba); end
    transfer();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_release: got %0b want 0", busy); end
  endtask

  task automatic test_ripple;
    int lat; bit ba;
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, lat, ba);
    checks++; if (out_s !== 32'h0000_0001 || out_cout !== 1'b1) begin errors++; $display("FAIL ripple_msb: got %0b_%h want 1_00000001", out_cout, out_s); end
    transfer();
    issue(32'h00FF_FFFF, 32'h0000_0001, 1'b0, lat, ba);
    checks++; if (out_s !== 32'h0100_0000 || out_cout !== 1'b0) begin errors++; $display("FAIL ripple_chunks: got %0b_%h want 0_01000000", out_cout, out_s); end
    transfer();
  endtask

  task automatic test_back_to_back;
    int lat; bit ba; logic [32:0] exp;
    exp = ref_add(32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
    issue(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, lat, ba);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if ({out_cout, out_s} !== exp || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %0b_%h want %h", out_cout, out_s, exp); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_stall: got %0b want 0", in_ready); end
    end
    in_a = 32'd1; in_b = 32'd2; in_cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0; in_a = $urandom; in_b = $urandom;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got valid=%0b busy=%0b want 0 1", out_valid, busy); end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin lat = k; break; end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d want 4", lat); end
    checks++; if (out_s !== 32'h3 || out_cout !== 1'b0) begin errors++; $display("FAIL b2b_sum: got %0b_%h want 0_00000003", out_cout, out_s); end
    transfer();
  endtask

  task automatic test_reset_mid;
    int lat; bit ba; bit spurious;
    in_a = 32'hAAAA_AAAA; in_b = 32'h5555_5555; in_cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_s !== 32'h0) begin errors++; $display("FAIL midrst_state: got busy=%0b valid=%0b s=%h want 0 0 0", busy, out_valid, out_s); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
    spurious = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(); spurious |= out_valid; end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL midrst_no_result: got %0b want 0", spurious); end
    issue(32'd5, 32'd7, 1'b0, lat, ba);
    checks++; if (lat !== 4 || out_s !== 32'h0000_000C || out_cout !== 1'b0) begin errors++; $display("FAIL midrst_after: got lat=%0d %0b_%h want 4 0_0000000c", lat, out_cout, out_s); end
    transfer();
  endtask

  task automatic test_narrow;
    int lat; logic [7:0] a, b; logic cin; logic [8:0] exp;
    for (int i = 0; i < 21; i++) begin
      if (i == 0) begin a = 8'hFF; b = 8'hFF; cin = 1'b1; end
      else begin a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); end
      exp = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      n_in_a = a; n_in_b = b; n_in_cin = cin; n_in_valid = 1'b1; n_out_ready = 1'b0;
      #1;
      checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL narrow_in_ready: got %0b want 1", n_in_ready); end
      tick();
      n_in_valid = 1'b0; n_in_a = 8'($urandom); n_in_b = 8'($urandom);
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (n_out_valid) begin lat = k; break; end
      end
      checks++; if (lat !== 1) begin errors++; $display("FAIL narrow_latency: got %0d want 1", lat); end
      checks++; if ({n_out_cout, n_out_s} !== exp) begin errors++; $display("FAIL narrow_sum: got %0b_%h want %h", n_out_cout, n_out_s, exp); end
      n_out_ready = 1'b1;
      tick();
      n_out_ready = 1'b0;
      checks++; if (n_busy !== 1'b0) begin errors++; $display("FAIL narrow_idle: got %0b want 0", n_busy); end
    end
  endtask

  task automatic test_random;
    logic [32:0] q[$];
    int issued = 0; int done = 0; int cyc = 0;
    logic [31:0] a, b; logic cin;
    while (done < 1000 && cyc < 30000) begin
      cyc++;
      a = pick_operand(); b = pick_operand(); cin = 1'($urandom);
      in_a = a; in_b = b; in_cin = cin;
      in_valid  = (issued < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: got out_valid=1 want 0 (nothing in flight)");
        end else begin
          if ({out_cout, out_s} !== q[0]) begin errors++; $display("FAIL rand_sum: got %0b_%h want %h", out_cout, out_s, q[0]); end
          if (out_ready) begin void'(q.pop_front()); done++; end
        end
      end
      if (in_valid && in_ready) begin q.push_back(ref_add(a, b, cin)); issued++; end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (done !== 1000) begin errors++; $display("FAIL rand_completed: got %0d want 1000", done); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_a = 32'd0; in_b = 32'd0; in_cin = 1'b0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_in_a = 8'd0; n_in_b = 8'd0; n_in_cin = 1'b0;
    test_reset();
    test_basic();
    test_busy();
    test_ripple();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
